// File: rtl/m_ifetch_queue.sv
// m_ifetch_queue: instruction fetch queue between the synchronous-read
// instruction memory and the ID stage.
//
// The block owns the fetch PC and issues one word read per cycle while
// credit allows, so that queued entries plus the read in flight never exceed
// DEPTH. Returned words are buffered with their byte PC and handed to ID
// under a valid/ready handshake. A redirect from ID flushes the queue, kills
// the in-flight read and restarts fetch at the target. Halt stops new fetches
// while the queue keeps draining.
//
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is presented to ID in the same cycle. If
// ID takes it, it is never written to the queue. When the macro is not
// defined, ID always sees the queue registers.
//
// Ports:
//   w_clk, w_rst_n    clock, asynchronous active-low reset
//   w_imem_re         read request this cycle
//   w_imem_addr       word address, fetch PC[ADDR_W+1:2]
//   w_imem_dout       read data, valid the cycle after the request
//   w_id_valid        head entry valid
//   w_id_ir           head instruction (NOP 32'h20 when invalid)
//   w_id_pc/w_id_pc4  head byte PC and PC+4
//   w_id_ready        ID accepts the head this cycle
//   w_redirect        taken branch: flush and refetch at w_redirect_pc
//   w_halt            stop issuing new fetches
module m_ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    output logic              w_imem_re,
    output logic [ADDR_W-1:0] w_imem_addr,
    input  logic [31:0]       w_imem_dout,
    output logic              w_id_valid,
    output logic [31:0]       w_id_ir,
    output logic [31:0]       w_id_pc,
    output logic [31:0]       w_id_pc4,
    input  logic              w_id_ready,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    input  logic              w_halt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0020;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t             state;
    state_t             state_nx;
    logic [31:0]        fetch_pc;
    logic [31:0]        inflight_pc;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        q_ir [DEPTH];
    logic [31:0]        q_pc [DEPTH];
    logic               issue;
    logic               q_empty;
    logic               bypass_hit;
    logic               push;
    logic               pop_q;

    // State register
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: redirect always returns to fetching, halt is sticky
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_RUN;
            S_RUN:   if (w_halt && !w_redirect) state_nx = S_HALT;
            S_HALT:  if (w_redirect) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // Issue decision. A pop in the same cycle does not give credit back, so
    // there is no combinational path from w_id_ready to the read request.
    always_comb begin
        issue = 1'b0;
        if ((state == S_RUN) && !w_redirect && !w_halt &&
            ((32'(count) + 32'(inflight)) < DEPTH)) begin
            issue = 1'b1;
        end
    end

    assign w_imem_re   = issue;
    assign w_imem_addr = fetch_pc[ADDR_W+1:2];
    assign q_empty     = (count == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = q_empty && inflight;
`else
    assign bypass_hit = 1'b0;
`endif

    assign pop_q = !q_empty && w_id_ready;
    // A bypassed word that ID consumes is never stored.
    assign push  = inflight && !w_redirect && !(bypass_hit && w_id_ready);

    // Head presentation to ID
    always_comb begin
        w_id_valid = 1'b0;
        w_id_ir    = NOP;
        w_id_pc    = 32'h0;
        if (!q_empty) begin
            w_id_valid = 1'b1;
            w_id_ir    = q_ir[rd_ptr];
            w_id_pc    = q_pc[rd_ptr];
        end else if (bypass_hit) begin
            w_id_valid = 1'b1;
            w_id_ir    = w_imem_dout;
            w_id_pc    = inflight_pc;
        end
    end

    assign w_id_pc4 = w_id_pc + 32'd4;

    // Fetch PC, in-flight tracking and queue bookkeeping
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= 32'h0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (w_redirect) begin
            fetch_pc <= w_redirect_pc & ~32'h3;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_q) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_q);
        end
    end

    // Queue storage; occupancy is tracked by count, so no reset is needed
    always_ff @(posedge w_clk) begin
        if (push) begin
            q_ir[wr_ptr] <= w_imem_dout;
            q_pc[wr_ptr] <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Testbench for m_ifetch_queue. A transaction-level reference model tracks
// every issued read as (issue cycle, byte PC) in a queue. A read becomes
// visible to ID a fixed latency after issue. It leaves the model when ID
// accepts it or a redirect or reset kills it. The credit limit is the number
// of live reads held by the model.
module tb_m_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 11;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0020;
    localparam logic [31:0] SALT     = 32'hC0DE_0000;
`ifdef IFQ_BYPASS_EN
    localparam int unsigned LAT = 1;
`else
    localparam int unsigned LAT = 2;
`endif

    logic              w_clk;
    logic              w_rst_n;
    logic              w_imem_re;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [31:0]       w_imem_dout;
    logic              w_id_valid;
    logic [31:0]       w_id_ir;
    logic [31:0]       w_id_pc;
    logic [31:0]       w_id_pc4;
    logic              w_id_ready;
    logic              w_redirect;
    logic [31:0]       w_redirect_pc;
    logic              w_halt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned m_cyc_q [$];
    logic [31:0] m_pc_q  [$];
    logic [31:0] m_fetch;
    bit          m_fetching;
    bit          m_fresh;
    int unsigned cyc;

    m_ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_re     (w_imem_re),
        .w_imem_addr   (w_imem_addr),
        .w_imem_dout   (w_imem_dout),
        .w_id_valid    (w_id_valid),
        .w_id_ir       (w_id_ir),
        .w_id_pc       (w_id_pc),
        .w_id_pc4      (w_id_pc4),
        .w_id_ready    (w_id_ready),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_halt        (w_halt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Synchronous-read instruction memory: the word at address a is a ^ SALT
    always @(posedge w_clk) begin
        if (w_imem_re) w_imem_dout <= 32'(w_imem_addr) ^ SALT;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'(pc[ADDR_W+1:2]) ^ SALT;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc_q.delete();
        m_pc_q.delete();
        m_fetch    = RESET_PC;
        m_fetching = 1'b0;
        m_fresh    = 1'b1;
        cyc        = 0;
    endtask

    // Assert reset between clock edges, check outputs at once, release on a negedge
    task automatic async_reset();
        #3;
        w_rst_n       = 1'b0;
        w_id_ready    = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_halt        = 1'b0;
        #1;
        check("rst_id_valid", 32'(w_id_valid), 32'h0);
        check("rst_id_ir", w_id_ir, NOP);
        check("rst_id_pc", w_id_pc, 32'h0);
        check("rst_id_pc4", w_id_pc4, 32'h4);
        check("rst_imem_re", 32'(w_imem_re), 32'h0);
        check("rst_imem_addr", 32'(w_imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs at the negedge, check, advance the model
    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc, input bit hlt);
        bit          exp_valid;
        bit          exp_re;
        int unsigned sz;
        w_id_ready    = rdy;
        w_redirect    = redir;
        w_redirect_pc = rpc;
        w_halt        = hlt;
        #1;
        sz        = m_cyc_q.size();
        exp_valid = 1'b0;
        if (sz > 0) exp_valid = ((cyc - m_cyc_q[0]) >= LAT);
        check("id_valid", 32'(w_id_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("id_pc", w_id_pc, m_pc_q[0]);
            check("id_pc4", w_id_pc4, m_pc_q[0] + 32'd4);
            check("id_ir", w_id_ir, exp_word(m_pc_q[0]));
        end else begin
            check("id_ir_nop", w_id_ir, NOP);
        end
        exp_re = m_fetching && !redir && !hlt && (sz < DEPTH);
        check("imem_re", 32'(w_imem_re), 32'(exp_re));
        if (exp_re) check("imem_addr", 32'(w_imem_addr), 32'(m_fetch[ADDR_W+1:2]));

        if (exp_valid && rdy) begin
            void'(m_cyc_q.pop_front());
            void'(m_pc_q.pop_front());
        end
        if (exp_re) begin
            m_cyc_q.push_back(cyc);
            m_pc_q.push_back(m_fetch);
            m_fetch = m_fetch + 32'd4;
        end
        if (redir) begin
            m_cyc_q.delete();
            m_pc_q.delete();
            m_fetch    = {rpc[31:2], 2'b00};
            m_fetching = 1'b1;
        end else if (m_fresh) begin
            m_fetching = 1'b1;
        end else if (hlt) begin
            m_fetching = 1'b0;
        end
        m_fresh = 1'b0;
        cyc++;
        @(negedge w_clk);
    endtask

    initial begin
        w_rst_n       = 1'b0;
        w_id_ready    = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_halt        = 1'b0;
        model_reset();

        // Reset, then stream with ID always ready
        async_reset();
        repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Backpressure: the queue fills to DEPTH and fetch stops
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect to 0x100 with entries queued and a read in flight
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Halt pulse: drain, stay empty, then resume at 0x40
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect latency to 0x200
        cycle(1'b1, 1'b1, 32'h200, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Unaligned target near the top of the address space: PC wraps to 0
        cycle(1'b1, 1'b1, 32'hFFFF_FFF7, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of a stream
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        async_reset();
        repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Randomized ready, redirects and halts
        repeat (400) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                  $urandom, ($urandom_range(0, 39) == 0));
        end
        repeat (8) cycle(1'b1, 1'b1, 32'h0000_0800, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
